// File: rtl/bus_ctrl_pkg.sv
// Shared constants for the single-bus processor control unit:
// opcodes, FSM state encoding, ALU operation codes and IR field positions.
package bus_ctrl_pkg;

  // Instruction opcodes (IR[15:13])
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_t;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  // IR field bit positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;
  localparam int RX_MSB = 12;
  localparam int RX_LSB = 10;
  localparam int RY_MSB = 9;
  localparam int RY_LSB = 7;

endpackage

// File: rtl/bus_ctrl_fsm_dec3to8.sv
// 3-bit register index plus enable to one-hot register select.
module dec3to8 #(
  parameter int NREG = 8
) (
  input  logic [2:0]      idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  // One-hot decode; all zeros when disabled
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/bus_ctrl_fsm.sv
// Control unit for the 16-bit single-bus datapath: fetches an instruction
// from din on run, then sequences it over 1-3 execute steps, driving the
// bus source selects and register load enables for each step.
module bus_ctrl_fsm
  import bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic              gnz,
  output logic              din_out,
  output logic [NREG-1:0]   r_out,
  output logic              g_out,
  output logic              dout_out,
  output logic [NREG-1:0]   r_in,
  output logic              a_in,
  output logic              g_in,
  output logic              addr_in,
  output logic              dout_in,
  output logic              w_d,
  output logic [1:0]        alu_op,
  output logic              done
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0] op_s, rx_s, ry_s;
  logic       ro_en_s, ri_en_s;
  logic [2:0] ro_idx_s, ri_idx_s;
  logic       ir_unused_s;

  assign op_s = ir_q[OP_MSB:OP_LSB];
  assign rx_s = ir_q[RX_MSB:RX_LSB];
  assign ry_s = ir_q[RY_MSB:RY_LSB];
  // Low IR bits carry no control information
  assign ir_unused_s = ^ir_q[RY_LSB-1:0];

  // Next-state, IR load and per-step control decode; reset forces all idle
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    din_out  = 1'b0;
    g_out    = 1'b0;
    dout_out = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    w_d      = 1'b0;
    alu_op   = ALU_ADD;
    done     = 1'b0;
    ro_en_s  = 1'b0;
    ro_idx_s = ry_s;
    ri_en_s  = 1'b0;
    ri_idx_s = rx_s;
    if (!resetn) begin
      state_d = IDLE;
      ir_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            din_out = 1'b1;
            ir_d    = din;
            state_d = T1;
          end else begin
            state_d = IDLE;
          end
        end
        T1: begin
          case (op_s)
            OP_MV: begin
              ro_en_s = 1'b1;
              ri_en_s = 1'b1;
              done    = 1'b1;
              state_d = IDLE;
            end
            OP_MVI: begin
              din_out = 1'b1;
              ri_en_s = 1'b1;
              done    = 1'b1;
              state_d = IDLE;
            end
            OP_ADD, OP_SUB, OP_SLT: begin
              ro_en_s  = 1'b1;
              ro_idx_s = rx_s;
              a_in     = 1'b1;
              state_d  = T2;
            end
            OP_LD, OP_ST: begin
              ro_en_s = 1'b1;
              addr_in = 1'b1;
              state_d = T2;
            end
            OP_MVNZ: begin
              ro_en_s = gnz;
              ri_en_s = gnz;
              done    = 1'b1;
              state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
        T2: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_SLT: begin
              ro_en_s = 1'b1;
              g_in    = 1'b1;
              if (op_s == OP_SUB) begin
                alu_op = ALU_SUB;
              end else if (op_s == OP_SLT) begin
                alu_op = ALU_SLT;
              end else begin
                alu_op = ALU_ADD;
              end
              state_d = T3;
            end
            // One-cycle memory read wait
            OP_LD: state_d = T3;
            OP_ST: begin
              ro_en_s  = 1'b1;
              ro_idx_s = rx_s;
              dout_in  = 1'b1;
              w_d      = 1'b1;
              done     = 1'b1;
              state_d  = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
        T3: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_SLT: begin
              g_out   = 1'b1;
              ri_en_s = 1'b1;
              done    = 1'b1;
              state_d = IDLE;
            end
            OP_LD: begin
              din_out = 1'b1;
              ri_en_s = 1'b1;
              done    = 1'b1;
              state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and instruction register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  dec3to8 #(.NREG(NREG)) u_dec_rout (
    .idx    (ro_idx_s),
    .en     (ro_en_s),
    .onehot (r_out)
  );

  dec3to8 #(.NREG(NREG)) u_dec_rin (
    .idx    (ri_idx_s),
    .en     (ri_en_s),
    .onehot (r_in)
  );

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
// Directed testbench for bus_ctrl_fsm with hand-computed expected outputs.
module tb_bus_ctrl_fsm;

  typedef struct packed {
    logic       din_out;
    logic [7:0] r_out;
    logic       g_out;
    logic       dout_out;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic [1:0] alu_op;
    logic       done;
  } outs_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        gnz;
  logic        din_out, g_out, dout_out, a_in, g_in, addr_in, dout_in, w_d, done;
  logic [7:0]  r_out, r_in;
  logic [1:0]  alu_op;
  outs_t       obs_s;
  outs_t       e;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  bus_ctrl_fsm #(.DATA_W(16), .NREG(8)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .run      (run),
    .din      (din),
    .gnz      (gnz),
    .din_out  (din_out),
    .r_out    (r_out),
    .g_out    (g_out),
    .dout_out (dout_out),
    .r_in     (r_in),
    .a_in     (a_in),
    .g_in     (g_in),
    .addr_in  (addr_in),
    .dout_in  (dout_in),
    .w_d      (w_d),
    .alu_op   (alu_op),
    .done     (done)
  );

  assign obs_s = '{din_out, r_out, g_out, dout_out, r_in, a_in, g_in,
                   addr_in, dout_in, w_d, alu_op, done};

  // Count one comparison and report it if it mismatches
  task automatic chk(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance just past the next rising edge
  task automatic cyc(input string tag, input outs_t exp);
    @(negedge clock);
    chk(tag, obs_s, exp);
    @(posedge clock);
    #1;
  endtask

  function automatic outs_t fetch_v();
    outs_t v;
    v = '0;
    v.din_out = 1'b1;
    return v;
  endfunction

  // Fetch and run a three-step ALU instruction
  task automatic run_alu(input string nm, input logic [15:0] ir,
                         input logic [7:0] rxm, input logic [7:0] rym,
                         input logic [1:0] op);
    outs_t v;
    run = 1'b1; din = ir;
    cyc({nm, "_fetch"}, fetch_v());
    run = 1'b0; din = 16'h0000;
    v = '0; v.r_out = rxm; v.a_in = 1'b1;
    cyc({nm, "_t1"}, v);
    v = '0; v.r_out = rym; v.g_in = 1'b1; v.alu_op = op;
    cyc({nm, "_t2"}, v);
    v = '0; v.g_out = 1'b1; v.r_in = rxm; v.done = 1'b1;
    cyc({nm, "_t3"}, v);
    cyc({nm, "_idle"}, outs_t'(0));
  endtask

  initial begin
    // Reset held with run=1
    resetn = 1'b0; run = 1'b1; din = 16'h2C00; gnz = 1'b0;
    cyc("rst_c0", outs_t'(0));
    cyc("rst_c1", outs_t'(0));
    resetn = 1'b1; run = 1'b0;
    cyc("rst_rel", outs_t'(0));

    // mvi R3, #0x00AA
    run = 1'b1; din = 16'h2C00;
    cyc("mvi_fetch", fetch_v());
    run = 1'b0; din = 16'h00AA;
    e = '0; e.din_out = 1'b1; e.r_in = 8'h08; e.done = 1'b1;
    cyc("mvi_t1", e);
    cyc("mvi_idle", outs_t'(0));

    // add R1,R2 / sub R1,R2 / slt R1,R2
    run_alu("add", 16'h4500, 8'h02, 8'h04, 2'b00);
    run_alu("sub", 16'h6500, 8'h02, 8'h04, 2'b01);
    run_alu("slt", 16'hE500, 8'h02, 8'h04, 2'b10);

    // st R4,[R5]
    run = 1'b1; din = 16'hB280;
    cyc("st_fetch", fetch_v());
    run = 1'b0; din = 16'h0000;
    e = '0; e.r_out = 8'h20; e.addr_in = 1'b1;
    cyc("st_t1", e);
    e = '0; e.r_out = 8'h10; e.dout_in = 1'b1; e.w_d = 1'b1; e.done = 1'b1;
    cyc("st_t2", e);
    cyc("st_idle", outs_t'(0));

    // mvnz R0,R7 with gnz=0 then gnz=1
    run = 1'b1; din = 16'hC380; gnz = 1'b0;
    cyc("mvnz0_fetch", fetch_v());
    run = 1'b0;
    e = '0; e.done = 1'b1;
    cyc("mvnz0_t1", e);
    run = 1'b1; gnz = 1'b1;
    cyc("mvnz1_fetch", fetch_v());
    run = 1'b0;
    e = '0; e.r_out = 8'h80; e.r_in = 8'h01; e.done = 1'b1;
    cyc("mvnz1_t1", e);
    gnz = 1'b0;

    // ld R0,[R1] complete
    run = 1'b1; din = 16'h8080;
    cyc("ld_fetch", fetch_v());
    run = 1'b0; din = 16'h1234;
    e = '0; e.r_out = 8'h02; e.addr_in = 1'b1;
    cyc("ld_t1", e);
    cyc("ld_t2", outs_t'(0));
    e = '0; e.din_out = 1'b1; e.r_in = 8'h01; e.done = 1'b1;
    cyc("ld_t3", e);

    // run held high: mv R2,R6 then mv R3,R3 back to back
    run = 1'b1; din = 16'h0B00;
    cyc("mv_fetch", fetch_v());
    din = 16'h0D80;
    e = '0; e.r_out = 8'h40; e.r_in = 8'h04; e.done = 1'b1;
    cyc("mv_t1", e);
    cyc("mvself_fetch", fetch_v());
    run = 1'b0; din = 16'h0000;
    e = '0; e.r_out = 8'h08; e.r_in = 8'h08; e.done = 1'b1;
    cyc("mvself_t1", e);
    cyc("mvself_idle", outs_t'(0));

    // ld with run in T1 ignored, reset asserted in T2 aborts it
    run = 1'b1; din = 16'h8080;
    cyc("abort_fetch", fetch_v());
    run = 1'b1; din = 16'h2C00;
    e = '0; e.r_out = 8'h02; e.addr_in = 1'b1;
    cyc("abort_t1", e);
    run = 1'b0; resetn = 1'b0;
    cyc("abort_rst", outs_t'(0));
    resetn = 1'b1;
    cyc("abort_after", outs_t'(0));
    cyc("abort_after2", outs_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
